// File: rtl/domd_sbox8_ctrl_pkg.sv
// Shared definitions for the DOM-d S-box front end: FSM encoding, randomness width
// and the share-packing index helper.
package domd_sbox8_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S0   = 3'd1,
      ST_S1   = 3'd2,
      ST_S2   = 3'd3,
      ST_S3   = 3'd4,
      ST_DONE = 3'd5
   } state_e;

   // Fresh randomness bits consumed by one S-box evaluation at order d.
   function automatic int rw_of(input int d);
      return 8 * d * (d + 1) / 2;
   endfunction

   // Bit position of share s of data bit b in a packed (d+1)-share byte.
   function automatic int shidx(input int b, input int s, input int d);
      return (d + 1) * b + s;
   endfunction

endpackage

// File: rtl/domd_sbox8_ctrl_if.sv
// Shared-byte input, randomness input and shared-byte output streams of the S-box
// front end; slave is the controller side, master the producer/consumer side.
interface domd_sbox8_ctrl_if
   import domd_sbox8_ctrl_pkg::*;
#(
   parameter int D  = 10,
   parameter int RW = rw_of(D)
);
   logic             in_valid;
   logic             in_ready;
   logic [8*D+7:0]   in_shares;
   logic             rnd_valid;
   logic             rnd_ready;
   logic [RW-1:0]    rnd;
   logic             out_valid;
   logic             out_ready;
   logic [8*D+7:0]   out_shares;

   modport slave (
      input  in_valid, in_shares, rnd_valid, rnd, out_ready,
      output in_ready, rnd_ready, out_valid, out_shares
   );

   modport master (
      output in_valid, in_shares, rnd_valid, rnd, out_ready,
      input  in_ready, rnd_ready, out_valid, out_shares
   );
endinterface

// File: rtl/domd_sbox8_ctrl.sv
// Sequencer for the DOM-d masked SKINNY-8 S-box: latches one shared byte plus its
// randomness word, steps the four stage enables and presents the shared result.
module domd_sbox8_ctrl
   import domd_sbox8_ctrl_pkg::*;
#(
   parameter int D  = 10,
   parameter int RW = rw_of(D)
) (
   input  logic              clk,
   input  logic              rst_n,
   domd_sbox8_ctrl_if.slave  bus,
   output logic [8*D+7:0]    sb_si,
   output logic [RW-1:0]     sb_r,
   output logic [3:0]        sb_en,
   input  logic [8*D+7:0]    sb_so
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [8*D+7:0]   r_sb_si;
   logic [RW-1:0]    r_sb_r;
   logic             w_slot;
   logic             w_accept;

   // Handshake: both streams are taken together or not at all; no data feeds these.
   always_comb begin
      w_slot        = (r_state == ST_IDLE) | ((r_state == ST_DONE) & bus.out_ready);
      w_accept      = bus.in_valid & bus.rnd_valid & w_slot;
      bus.in_ready  = bus.rnd_valid & w_slot;
      bus.rnd_ready = bus.in_valid & w_slot;
   end

   // Next-state logic: fixed four-step walk, DONE holds until drained.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_S0;
            else          w_state_nxt = ST_IDLE;
         end
         ST_S0:   w_state_nxt = ST_S1;
         ST_S1:   w_state_nxt = ST_S2;
         ST_S2:   w_state_nxt = ST_S3;
         ST_S3:   w_state_nxt = ST_DONE;
         ST_DONE: begin
            if (w_accept)           w_state_nxt = ST_S0;
            else if (bus.out_ready) w_state_nxt = ST_IDLE;
            else                    w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Operand registers; randomness is wiped once consumed, shares once drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sb_si <= '0;
         r_sb_r  <= '0;
      end else if (w_accept) begin
         r_sb_si <= bus.in_shares;
         r_sb_r  <= bus.rnd;
      end else begin
         if (r_state == ST_S3)                      r_sb_r  <= '0;
         if ((r_state == ST_DONE) && bus.out_ready) r_sb_si <= '0;
      end
   end

   // Stage enables and output presentation, decoded from the state alone.
   always_comb begin
      sb_en          = 4'b0000;
      bus.out_valid  = 1'b0;
      bus.out_shares = '0;
      case (r_state)
         ST_S0:   sb_en = 4'b0001;
         ST_S1:   sb_en = 4'b0010;
         ST_S2:   sb_en = 4'b0100;
         ST_S3:   sb_en = 4'b1000;
         ST_DONE: begin
            bus.out_valid  = 1'b1;
            bus.out_shares = sb_so;
         end
         default: sb_en = 4'b0000;
      endcase
   end

   assign sb_si = r_sb_si;
   assign sb_r  = r_sb_r;

endmodule

// File: tb/tb_domd_sbox8_ctrl.sv
// Self-checking bench for domd_sbox8_ctrl at d=2, with a behavioural S-box stand-in.
module tb_domd_sbox8_ctrl;
   import domd_sbox8_ctrl_pkg::*;

   localparam int D  = 2;
   localparam int RW = 8 * D * (D + 1) / 2;
   localparam int W  = 8 * D + 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  sb_si;
   logic [RW-1:0] sb_r;
   logic [3:0]    sb_en;
   logic [W-1:0]  sb_so = '0;
   int            n_tests = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   domd_sbox8_ctrl_if #(.D(D), .RW(RW)) bus ();

   domd_sbox8_ctrl #(.D(D), .RW(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .sb_si (sb_si),
      .sb_r  (sb_r),
      .sb_en (sb_en),
      .sb_so (sb_so)
   );

   // SKINNY-128 8-bit S-box, bit-sliced definition
   function automatic logic [7:0] ref_sbox(input logic [7:0] xi);
      logic [7:0] x, y;
      x = ~xi;
      x = x ^ (((x >> 2) & (x >> 3)) & 8'h11);
      y = ((x << 5) & (x << 1)) & 8'h20;
      x = x ^ (((x << 5) & (x << 4)) & 8'h40) ^ y;
      y = ((x << 2) & (x << 1)) & 8'h80;
      x = x ^ (((x >> 2) & (x << 1)) & 8'h02) ^ y;
      y = ((x >> 5) & (x << 1)) & 8'h04;
      x = x ^ (((x >> 1) & (x >> 2)) & 8'h08) ^ y;
      x = ~x;
      return ((x & 8'h08) << 1) | ((x & 8'h32) << 2) | ((x & 8'h01) << 5) |
             ((x & 8'h80) >> 6) | ((x & 8'h40) >> 4) | ((x & 8'h04) >> 2);
   endfunction

   function automatic logic [7:0] unmask(input logic [W-1:0] s);
      logic [7:0] v;
      for (int b = 0; b < 8; b++) begin
         v[b] = 1'b0;
         for (int j = 0; j <= D; j++) v[b] = v[b] ^ s[shidx(b, j, D)];
      end
      return v;
   endfunction

   function automatic logic [W-1:0] remask(input logic [7:0] v, input logic [RW-1:0] r);
      logic [W-1:0] s;
      logic acc;
      for (int b = 0; b < 8; b++) begin
         acc = v[b];
         for (int j = 1; j <= D; j++) begin
            s[shidx(b, j, D)] = r[b*D + j - 1];
            acc = acc ^ r[b*D + j - 1];
         end
         s[shidx(b, 0, D)] = acc;
      end
      return s;
   endfunction

   function automatic logic [RW-1:0] rand_rnd();
      logic [31:0] t;
      t = $urandom();
      return t[RW-1:0];
   endfunction

   // S-box stand-in: unmask on stage 0, substitute, re-share with sb_r on stage 3
   logic [7:0] m_v0, m_v1, m_v2;
   always @(posedge clk) begin
      if (sb_en[0]) m_v0 <= unmask(sb_si);
      if (sb_en[1]) m_v1 <= ref_sbox(m_v0);
      if (sb_en[2]) m_v2 <= m_v1;
      if (sb_en[3]) sb_so <= remask(m_v2, sb_r);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // present one shared byte with randomness for exactly the accepting edge
   task automatic send(input logic [7:0] v, input logic [RW-1:0] r);
      bus.in_valid  = 1'b1;
      bus.rnd_valid = 1'b1;
      bus.in_shares = remask(v, rand_rnd());
      bus.rnd       = r;
      cyc();
      bus.in_valid  = 1'b0;
      bus.rnd_valid = 1'b0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if (sb_en !== 4'b0000 || bus.out_valid !== 1'b0 || bus.out_shares !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: en=%b valid=%b shares=%h, want 0/0/0", sb_en, bus.out_valid, bus.out_shares);
      end
      n_tests++;
      if (sb_si !== '0 || sb_r !== '0) begin
         n_fail++;
         $display("FAIL reset_regs: sb_si=%h sb_r=%h, want 0", sb_si, sb_r);
      end
      n_tests++;
      if (bus.in_ready !== 1'b0 || bus.rnd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: in_ready=%b rnd_ready=%b, want 0/0", bus.in_ready, bus.rnd_ready);
      end
      bus.in_valid = 1'b1;
      #1;
      n_tests++;
      if (bus.rnd_ready !== 1'b1 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready_skew: in_ready=%b rnd_ready=%b, want 0/1", bus.in_ready, bus.rnd_ready);
      end
      bus.in_valid = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_single();
      logic [3:0] exp_en;
      logic [RW-1:0] r;
      r = rand_rnd();
      bus.in_valid  = 1'b1;
      bus.rnd_valid = 1'b1;
      bus.in_shares = remask(8'h00, rand_rnd());
      bus.rnd       = r;
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1 || bus.rnd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready: in_ready=%b rnd_ready=%b, want 1/1", bus.in_ready, bus.rnd_ready);
      end
      cyc();
      bus.in_valid  = 1'b0;
      bus.rnd_valid = 1'b0;
      exp_en = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (sb_en !== exp_en || bus.out_valid !== 1'b0 || sb_r !== r) begin
            n_fail++;
            $display("FAIL single_stage%0d: en=%b valid=%b sb_r=%h, want %b/0/%h", k, sb_en, bus.out_valid, sb_r, exp_en, r);
         end
         exp_en = exp_en << 1;
         cyc();
      end
      n_tests++;
      if (bus.out_valid !== 1'b1 || unmask(bus.out_shares) !== 8'h65 || sb_r !== '0 || sb_en !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_result: valid=%b value=%h sb_r=%h en=%b, want 1/65/0/0000",
                  bus.out_valid, unmask(bus.out_shares), sb_r, sb_en);
      end
      drain();
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.out_shares !== '0 || sb_si !== '0) begin
         n_fail++;
         $display("FAIL single_drain: valid=%b shares=%h sb_si=%h, want 0/0/0", bus.out_valid, bus.out_shares, sb_si);
      end
   endtask

   task automatic test_hold_ff();
      logic [W-1:0] held;
      send(8'hFF, rand_rnd());
      repeat (4) cyc();
      held = bus.out_shares;
      for (int k = 0; k < 10; k++) begin
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.out_shares !== held || unmask(bus.out_shares) !== 8'hFF || sb_r !== '0) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: valid=%b value=%h sb_r=%h, want 1/ff/0 with stable shares",
                     k, bus.out_valid, unmask(bus.out_shares), sb_r);
         end
         cyc();
      end
      drain();
   endtask

   task automatic test_back_to_back();
      bus.in_valid  = 1'b1;
      bus.rnd_valid = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         bus.in_shares = remask(i[7:0], rand_rnd());
         bus.rnd       = rand_rnd();
         #1;
         n_tests++;
         if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept%0d: in_ready=%b, want 1", i, bus.in_ready);
         end
         cyc();
         n_tests++;
         if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy%0d: in_ready=%b, want 0", i, bus.in_ready);
         end
         repeat (4) cyc();
         n_tests++;
         if (bus.out_valid !== 1'b1 || unmask(bus.out_shares) !== ref_sbox(i[7:0])) begin
            n_fail++;
            $display("FAIL b2b_result%0d: valid=%b value=%h, want 1/%h", i, bus.out_valid, unmask(bus.out_shares), ref_sbox(i[7:0]));
         end
      end
      bus.in_valid  = 1'b0;
      bus.rnd_valid = 1'b0;
      cyc();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_skew();
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      bus.in_valid  = 1'b1;
      bus.rnd_valid = 1'b0;
      bus.in_shares = remask(v, rand_rnd());
      bus.rnd       = rand_rnd();
      for (int k = 0; k < 7; k++) begin
         #1;
         n_tests++;
         if (bus.rnd_ready !== 1'b1 || bus.in_ready !== 1'b0 || sb_en !== 4'b0000) begin
            n_fail++;
            $display("FAIL skew_wait%0d: rnd_ready=%b in_ready=%b en=%b, want 1/0/0000", k, bus.rnd_ready, bus.in_ready, sb_en);
         end
         cyc();
      end
      bus.rnd_valid = 1'b1;
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL skew_release: in_ready=%b, want 1", bus.in_ready);
      end
      cyc();
      bus.in_valid  = 1'b0;
      bus.rnd_valid = 1'b0;
      n_tests++;
      if (sb_en !== 4'b0001) begin
         n_fail++;
         $display("FAIL skew_accepted: en=%b, want 0001", sb_en);
      end
      repeat (4) cyc();
      n_tests++;
      if (bus.out_valid !== 1'b1 || unmask(bus.out_shares) !== ref_sbox(v)) begin
         n_fail++;
         $display("FAIL skew_result: valid=%b value=%h, want 1/%h", bus.out_valid, unmask(bus.out_shares), ref_sbox(v));
      end
      drain();
   endtask

   task automatic test_reset_midop();
      logic [7:0] v;
      send(8'h3C, rand_rnd());
      cyc();
      cyc();
      n_tests++;
      if (sb_en !== 4'b0100) begin
         n_fail++;
         $display("FAIL midop_in_s2: en=%b, want 0100", sb_en);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (sb_en !== 4'b0000 || bus.out_valid !== 1'b0 || sb_si !== '0 || sb_r !== '0 || bus.out_shares !== '0) begin
         n_fail++;
         $display("FAIL midop_reset: en=%b valid=%b sb_si=%h sb_r=%h shares=%h, want all 0",
                  sb_en, bus.out_valid, sb_si, sb_r, bus.out_shares);
      end
      repeat (3) cyc();
      rst_n = 1'b1;
      repeat (4) cyc();
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.out_shares !== '0) begin
         n_fail++;
         $display("FAIL midop_no_stale: valid=%b shares=%h, want 0/0", bus.out_valid, bus.out_shares);
      end
      v = 8'($urandom_range(0, 255));
      send(v, rand_rnd());
      repeat (4) cyc();
      n_tests++;
      if (bus.out_valid !== 1'b1 || unmask(bus.out_shares) !== ref_sbox(v)) begin
         n_fail++;
         $display("FAIL midop_fresh: valid=%b value=%h, want 1/%h", bus.out_valid, unmask(bus.out_shares), ref_sbox(v));
      end
      drain();
   endtask

   task automatic test_rnd_independence();
      logic [7:0] v;
      logic [RW-1:0] r1;
      logic [W-1:0] s1, s2;
      v  = 8'($urandom_range(0, 255));
      r1 = rand_rnd();
      send(v, r1);
      repeat (4) cyc();
      s1 = bus.out_shares;
      drain();
      send(v, ~r1);
      repeat (4) cyc();
      s2 = bus.out_shares;
      drain();
      n_tests++;
      if (unmask(s1) !== ref_sbox(v) || unmask(s2) !== ref_sbox(v)) begin
         n_fail++;
         $display("FAIL indep_value: run1=%h run2=%h, want %h", unmask(s1), unmask(s2), ref_sbox(v));
      end
      n_tests++;
      if (s1 === s2) begin
         n_fail++;
         $display("FAIL indep_shares: run1=%h run2=%h, want differing share vectors", s1, s2);
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.rnd_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_shares = '0;
      bus.rnd       = '0;
      test_reset();
      test_single();
      test_hold_ff();
      test_back_to_back();
      test_skew();
      test_reset_midop();
      test_rnd_independence();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
